// File: rtl/wb_regfile_unit_if.sv
// Writeback/register-file bus between the MEM/WB stage, decode and fetch.
// master = pipeline side driving writeback and read addresses; slave = wb_regfile_unit.
interface wb_regfile_unit_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                   reg_write_enable_in;
    logic                   mem_to_reg_select_in;
    logic [DATA_WIDTH-1:0]  alu_result_in;
    logic [DATA_WIDTH-1:0]  mem_data_in;
    logic [3:0]             dest_reg_in;
    logic                   instr_valid_in;
    logic [DATA_WIDTH-1:0]  pc_plus8_in;
    logic [3:0]             rd_addr_a;
    logic [3:0]             rd_addr_b;
    logic [3:0]             rd_addr_c;
    logic [DATA_WIDTH-1:0]  rd_data_a;
    logic [DATA_WIDTH-1:0]  rd_data_b;
    logic [DATA_WIDTH-1:0]  rd_data_c;
    logic [DATA_WIDTH-1:0]  wb_data_out;
    logic [3:0]             wb_dest_out;
    logic                   wb_write_out;
    logic                   pc_write_out;
    logic [DATA_WIDTH-1:0]  pc_write_data_out;
    logic [COUNT_WIDTH-1:0] retire_count_out;

    modport master (
        output reg_write_enable_in, mem_to_reg_select_in, alu_result_in, mem_data_in,
               dest_reg_in, instr_valid_in, pc_plus8_in, rd_addr_a, rd_addr_b, rd_addr_c,
        input  rd_data_a, rd_data_b, rd_data_c, wb_data_out, wb_dest_out, wb_write_out,
               pc_write_out, pc_write_data_out, retire_count_out
    );

    modport slave (
        input  reg_write_enable_in, mem_to_reg_select_in, alu_result_in, mem_data_in,
               dest_reg_in, instr_valid_in, pc_plus8_in, rd_addr_a, rd_addr_b, rd_addr_c,
        output rd_data_a, rd_data_b, rd_data_c, wb_data_out, wb_dest_out, wb_write_out,
               pc_write_out, pc_write_data_out, retire_count_out
    );
endinterface

// File: rtl/wb_regfile_unit.sv
// Writeback stage: result mux, 16-entry ARM register file, R15 redirect pulse, retire counter.
// Optional WB_REGFILE_BYPASS_EN: same-cycle write-through on the three read ports.
module wb_regfile_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned PC_INDEX    = 15
) (
    input logic               clk,
    input logic               reset,
    wb_regfile_unit_if.slave  bus
);
    localparam logic [3:0] PC_IDX = 4'(PC_INDEX);

    logic [DATA_WIDTH-1:0]  regs [16];
    logic [DATA_WIDTH-1:0]  wb_data;
    logic                   we;
    logic                   pc_write_q;
    logic [DATA_WIDTH-1:0]  pc_data_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [3:0]             rd_addr [3];
    logic [DATA_WIDTH-1:0]  rd_data [3];

    // Writeback select and qualified write enable (bubbles never write)
    assign wb_data = bus.mem_to_reg_select_in ? bus.mem_data_in : bus.alu_result_in;
    assign we      = bus.reg_write_enable_in & bus.instr_valid_in;

    // Register storage; the PC slot is never written since reads of it return pc_plus8_in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we && bus.dest_reg_in != PC_IDX) begin
            regs[bus.dest_reg_in] <= wb_data;
        end
    end

    // Redirect pulse stays high across back-to-back R15 writes; target holds otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_write_q <= 1'b0;
            pc_data_q  <= '0;
        end else begin
            pc_write_q <= we && (bus.dest_reg_in == PC_IDX);
            if (we && bus.dest_reg_in == PC_IDX) pc_data_q <= wb_data;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  count_q <= '0;
        else if (bus.instr_valid_in) count_q <= count_q + COUNT_WIDTH'(1);
    end

    assign rd_addr[0] = bus.rd_addr_a;
    assign rd_addr[1] = bus.rd_addr_b;
    assign rd_addr[2] = bus.rd_addr_c;

    // Combinational read ports
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_data[i] = regs[rd_addr[i]];
            if (rd_addr[i] == PC_IDX) begin
                rd_data[i] = bus.pc_plus8_in;
            end
`ifdef WB_REGFILE_BYPASS_EN
            else if (we && rd_addr[i] == bus.dest_reg_in) begin
                rd_data[i] = wb_data;
            end
`endif
        end
    end

    assign bus.rd_data_a         = rd_data[0];
    assign bus.rd_data_b         = rd_data[1];
    assign bus.rd_data_c         = rd_data[2];
    assign bus.wb_data_out       = wb_data;
    assign bus.wb_dest_out       = bus.dest_reg_in;
    assign bus.wb_write_out      = we;
    assign bus.pc_write_out      = pc_write_q;
    assign bus.pc_write_data_out = pc_data_q;
    assign bus.retire_count_out  = count_q;
endmodule

// File: tb/tb_wb_regfile_unit.sv
// Self-checking bench for wb_regfile_unit: directed steps plus random traffic against an array model.
// An 8-bit retire counter is used so the wrap case is reachable in a short run.
module tb_wb_regfile_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    wb_regfile_unit_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    wb_regfile_unit #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .PC_INDEX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_regs [16];
    logic        m_pcw;
    logic [31:0] m_pcd;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a, input logic eff,
                                             input logic [3:0] dest, input logic [31:0] wbd,
                                             input logic [31:0] pc8);
        if (a == 4'd15) return pc8;
`ifdef WB_REGFILE_BYPASS_EN
        if (eff && a == dest) return wbd;
`endif
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pcw   = 1'b0;
        m_pcd   = '0;
        m_count = 0;
    endtask

    task automatic check_regs_out(input string tag);
        check({tag, ".pcw"},   32'(bus.pc_write_out),      32'(m_pcw));
        check({tag, ".pcd"},   bus.pc_write_data_out,      m_pcd);
        check({tag, ".count"}, 32'(bus.retire_count_out),  32'(m_count));
    endtask

    // One clock of traffic: drive, check combinational outputs, clock, update model, check registers
    task automatic step(input string tag, input logic wen, input logic sel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dest,
                        input logic valid, input logic [31:0] pc8,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
        logic        eff;
        logic [31:0] wbd;
        bus.reg_write_enable_in  = wen;
        bus.mem_to_reg_select_in = sel;
        bus.alu_result_in        = alu;
        bus.mem_data_in          = mem;
        bus.dest_reg_in          = dest;
        bus.instr_valid_in       = valid;
        bus.pc_plus8_in          = pc8;
        bus.rd_addr_a            = ra;
        bus.rd_addr_b            = rb;
        bus.rd_addr_c            = rc;
        eff = wen & valid;
        wbd = sel ? mem : alu;
        #1;
        check({tag, ".wbd"},  bus.wb_data_out,        wbd);
        check({tag, ".wbw"},  32'(bus.wb_write_out),  32'(eff));
        check({tag, ".wbdst"}, 32'(bus.wb_dest_out),  32'(dest));
        check({tag, ".rda"},  bus.rd_data_a, exp_read(ra, eff, dest, wbd, pc8));
        check({tag, ".rdb"},  bus.rd_data_b, exp_read(rb, eff, dest, wbd, pc8));
        check({tag, ".rdc"},  bus.rd_data_c, exp_read(rc, eff, dest, wbd, pc8));
        @(posedge clk);
        if (eff && dest != 4'd15) m_regs[dest] = wbd;
        m_pcw = eff && dest == 4'd15;
        if (m_pcw) m_pcd = wbd;
        if (valid) m_count = (m_count + 1) % (1 << CW);
        #1;
        check_regs_out(tag);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        model_reset();
        bus.reg_write_enable_in  = 1'b1;
        bus.mem_to_reg_select_in = 1'b0;
        bus.alu_result_in        = 32'hFFFF_FFFF;
        bus.mem_data_in          = '0;
        bus.dest_reg_in          = 4'd2;
        bus.instr_valid_in       = 1'b1;
        bus.pc_plus8_in          = 32'h0000_0108;
        bus.rd_addr_a            = '0;
        bus.rd_addr_b            = '0;
        bus.rd_addr_c            = '0;
        // Held in reset across edges with write traffic: nothing may change
        repeat (2) @(negedge clk);
        check_regs_out("rst");
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr_a = 4'(a);
            #1;
            check("rst.read", bus.rd_data_a, (a == 15) ? 32'h0000_0108 : 32'h0);
        end
        bus.reg_write_enable_in = 1'b0;
        bus.instr_valid_in      = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        step("alu3",   1, 0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd3, 1, 32'h108, 3, 0, 15);
        step("rd3a",   0, 0, 32'h0, 32'h0, 4'd0, 1, 32'h10C, 3, 3, 3);
        step("mem3",   1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd3, 1, 32'h110, 3, 1, 2);
        step("rd3b",   0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h114, 3, 4, 15);
        step("bubble", 1, 0, 32'hFFFF_FFFF, 32'h0, 4'd4, 0, 32'h118, 4, 4, 4);
        step("rd4",    0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h118, 4, 3, 15);
        step("pc",     1, 0, 32'h0000_8000, 32'h0, 4'd15, 1, 32'h11C, 15, 15, 15);
        step("pcdrop", 0, 0, 32'h0, 32'h0, 4'd15, 1, 32'h120, 15, 0, 15);
        step("pcb2b1", 1, 0, 32'h0000_9000, 32'h0, 4'd15, 1, 32'h124, 15, 3, 4);
        step("pcb2b2", 1, 1, 32'h0, 32'h0000_A000, 4'd15, 1, 32'h128, 15, 3, 4);
        step("pcend",  0, 0, 32'h0, 32'h0, 4'd15, 0, 32'h12C, 15, 3, 4);
        step("r7same", 1, 0, 32'hA5A5_A5A5, 32'h0, 4'd7, 1, 32'h130, 7, 7, 6);
        step("r7aft",  0, 0, 32'h0, 32'h0, 4'd0, 1, 32'h134, 7, 7, 7);

        // Counter wrap: run valids up to the all-ones value, then one more
        for (int k = 0; k < 300 && m_count != (1 << CW) - 1; k++)
            step("cnt", 0, 0, 32'h0, 32'h0, 4'd0, 1, 32'h0, 0, 1, 2);
        check("cnt.max", 32'(bus.retire_count_out), 32'((1 << CW) - 1));
        step("wrap", 0, 0, 32'h0, 32'h0, 4'd0, 1, 32'h0, 0, 1, 2);

        // Random traffic
        for (int k = 0; k < 400; k++)
            step("rand", 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom),
                 1'($urandom_range(0, 3) != 0), $urandom,
                 4'($urandom), 4'($urandom), 4'($urandom));

        // Reset asserted mid-redirect must clear state without a clock edge
        step("pcpre", 1, 0, 32'h0000_4444, 32'h0, 4'd15, 1, 32'h200, 1, 2, 3);
        check("pcpre.hi", 32'(bus.pc_write_out), 32'h1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_regs_out("arst");
        bus.rd_addr_a = 4'd7;
        #1;
        check("arst.r7", bus.rd_data_a, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step("post", 1, 0, 32'h0000_0077, 32'h0, 4'd5, 1, 32'h300, 5, 7, 15);
        step("post2", 0, 0, 32'h0, 32'h0, 4'd0, 0, 32'h304, 5, 5, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
Consumer end of the MEM/WB pipeline register. It takes the latched writeback control and data bundle, selects ALU result or memory data, and commits the value into a 16-entry ARM register file. Three combinational read ports serve decode (Rn, Rm, Rs/Rd store data). Writes to R15 become a registered branch-redirect pulse toward fetch, and a retired-instruction counter runs alongside.

Parameters:
DATA_WIDTH, 32, width of registers and datapath
COUNT_WIDTH, 32, width of retired-instruction counter
PC_INDEX, 15, register index treated as the program counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (0 = reset asserted)
reg_write_enable_in  in  1  commit writeback this cycle
mem_to_reg_select_in  in  1  1 = mem_data_in, 0 = alu_result_in
alu_result_in  in  DATA_WIDTH  ALU result from MEM/WB
mem_data_in  in  DATA_WIDTH  load data from MEM/WB
dest_reg_in  in  4  destination register index
instr_valid_in  in  1  1 = real instruction, 0 = bubble
pc_plus8_in  in  DATA_WIDTH  value returned on reads of R15
rd_addr_a / rd_addr_b / rd_addr_c  in  4 each  read addresses
rd_data_a / rd_data_b / rd_data_c  out  DATA_WIDTH each  read data
wb_data_out  out  DATA_WIDTH  selected writeback value, combinational (to forwarding unit)
wb_dest_out  out  4  equals dest_reg_in
wb_write_out  out  1  reg_write_enable_in AND instr_valid_in
pc_write_out  out  1  registered one-cycle redirect pulse
pc_write_data_out  out  DATA_WIDTH  redirect target
retire_count_out  out  COUNT_WIDTH  retired-instruction count

Behaviour:
- wb_data_out = mem_to_reg_select_in ? mem_data_in : alu_result_in (pure mux, no latency).
- Effective write: we = reg_write_enable_in & instr_valid_in. A bubble never writes, even with enable high.
- R0..R14: on posedge clk with we=1 and dest_reg_in != PC_INDEX, reg[dest] <= wb_data_out.
- R15 is not stored. With we=1 and dest_reg_in == PC_INDEX: next edge sets pc_write_out=1 and pc_write_data_out=wb_data_out.
  - pc_write_out is high exactly one cycle unless the next cycle also writes R15; back-to-back R15 writes hold it high with updated data.
  - pc_write_data_out holds its last value when pc_write_out=0.
- Reads are combinational. Address PC_INDEX returns pc_plus8_in. Other addresses return stored contents. All three ports are independent, so identical addresses are legal.
- Same-cycle read of the register being written returns the old value; the new value appears after the edge (see optional feature).
- retire_count_out increments by 1 on each posedge with instr_valid_in=1, independent of we. It wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Reset (reset=0, asynchronous, any time including mid-redirect):
  - R0..R14 = 0, pc_write_out = 0, pc_write_data_out = 0, retire_count_out = 0.
  - Combinational outputs still follow their inputs.
  - No writes or counts occur while reset is low.
  - Release is synchronous to the next rising edge in normal operation; the first edge after release can write.

Optional Feature:
WB_REGFILE_BYPASS_EN
- Defined: a read port whose address equals dest_reg_in while we=1 and the address != PC_INDEX returns wb_data_out in the same cycle (write-through). This removes the WB to decode hazard.
- Undefined: the old value is returned as described above, and the hazard unit must stall one cycle.

Test Plan:
- Reset, then read all addresses with pc_plus8_in=0x00000108 -> R0..R14 read 0; R15 reads 0x00000108; retire_count_out=0; pc_write_out=0.
- we, dest=3, mem_to_reg=0, alu=0xDEADBEEF, mem=0x12345678 -> after edge rd_addr_a=3 reads 0xDEADBEEF. Repeat with mem_to_reg=1 -> reads 0x12345678.
- reg_write_enable_in=1, instr_valid_in=0, dest=4, alu=0xFFFFFFFF -> R4 stays 0 and retire_count_out is unchanged.
- we, dest=15, alu=0x00008000 -> next cycle pc_write_out=1 and pc_write_data_out=0x00008000. The cycle after, pc_write_out=0. R15 read still returns pc_plus8_in.
- Write R7=0xA5A5A5A5 and read R7 in the same cycle -> 0 without the macro, 0xA5A5A5A5 with WB_REGFILE_BYPASS_EN. After the edge, both builds read 0xA5A5A5A5.
- Preload count to 0xFFFFFFFF via 2^32-1 valids (or force), then one valid -> 0. Assert reset mid-redirect -> pc_write_out drops to 0 immediately without waiting for a clock edge.
